// File: rtl/gcd_pkg.sv
// Shared GCD types: FSM state encoding and default operand width.
package gcd_pkg;

    localparam int GCD_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } gcd_state_t;

endpackage

// File: rtl/gcd_if.sv
// Operand load / result bus between a requester (master) and gcd_unit (slave).
interface gcd_if
    import gcd_pkg::*;
#(
    parameter int W = GCD_W
);

    logic [W-1:0] io_value1;
    logic [W-1:0] io_value2;
    logic         io_loadingValues;
    logic [W-1:0] io_outputGCD;
    logic         io_outputValid;

    modport master (
        output io_value1,
        output io_value2,
        output io_loadingValues,
        input  io_outputGCD,
        input  io_outputValid
    );

    modport slave (
        input  io_value1,
        input  io_value2,
        input  io_loadingValues,
        output io_outputGCD,
        output io_outputValid
    );

endinterface

// File: rtl/gcd_step.sv
// One subtractive-Euclid step: swap when x is zero, otherwise subtract smaller from larger.
// Purely combinational; y_zero flags that x already holds the result.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int W = GCD_W
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] next_x,
    output logic [W-1:0] next_y,
    output logic         y_zero
);

    always_comb begin
        y_zero = (y == '0);
        next_x = x;
        next_y = y;
        if (y_zero) begin
            next_x = x;
        end else if (x == '0) begin
            next_x = y;
            next_y = '0;
        end else if (x > y) begin
            next_x = x - y;
        end else begin
            next_y = y - x;
        end
    end

endmodule

// File: rtl/gcd_unit.sv
// Iterative GCD: operands captured on a load strobe, result registered with a valid flag.
// Latency is data dependent (BUSY steps + 1 edges); a new load always preempts the current job.
module gcd_unit
    import gcd_pkg::*;
#(
    parameter int W = GCD_W
) (
    input logic   clock,
    input logic   reset,
    gcd_if.slave  bus
);

    gcd_state_t   state;
    gcd_state_t   state_n;
    logic [W-1:0] x;
    logic [W-1:0] x_n;
    logic [W-1:0] y;
    logic [W-1:0] y_n;
    logic [W-1:0] gcd_q;
    logic [W-1:0] gcd_n;
    logic         valid_q;
    logic         valid_n;

    logic [W-1:0] step_x;
    logic [W-1:0] step_y;
    logic         y_zero;

    gcd_step #(.W(W)) u_step (
        .x      (x),
        .y      (y),
        .next_x (step_x),
        .next_y (step_y),
        .y_zero (y_zero)
    );

    always_comb begin
        state_n = state;
        x_n     = x;
        y_n     = y;
        gcd_n   = gcd_q;
        valid_n = valid_q;
        if (bus.io_loadingValues) begin
            x_n     = bus.io_value1;
            y_n     = bus.io_value2;
            state_n = BUSY;
            valid_n = 1'b0;
        end else begin
            case (state)
                BUSY: begin
                    if (y_zero) begin
                        state_n = DONE;
                        gcd_n   = x;
                        valid_n = 1'b1;
                    end else begin
                        x_n = step_x;
                        y_n = step_y;
                    end
                end
                default: begin
                    state_n = state;
                end
            endcase
        end
    end

    // Reset is sampled first so it wins over a simultaneous load.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            x       <= '0;
            y       <= '0;
            gcd_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_n;
            x       <= x_n;
            y       <= y_n;
            gcd_q   <= gcd_n;
            valid_q <= valid_n;
        end
    end

    assign bus.io_outputGCD   = gcd_q;
    assign bus.io_outputValid = valid_q;

endmodule

// File: tb/tb_gcd_unit.sv
// Directed and randomized checks of gcd_unit against a modulo-based Euclid reference.
module tb_gcd_unit;
    import gcd_pkg::*;

    localparam int W       = GCD_W;
    localparam int MAX_LAT = (1 << W) + 1;

    logic clock = 1'b0;
    logic reset = 1'b0;

    gcd_if #(.W(W)) bus ();

    gcd_unit #(.W(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;

    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Loads (a,b) for one edge, scrambles the idle operand inputs while waiting,
    // and checks result, latency and that valid was low on the load edge.
    task automatic run_pair(input int a, input int b, input int exp_lat, input string tag);
        int lat;
        logic [31:0] av;
        logic [31:0] bv;
        lat = 0;
        av  = a;
        bv  = b;
        bus.io_value1        = av[W-1:0];
        bus.io_value2        = bv[W-1:0];
        bus.io_loadingValues = 1'b1;
        tick();
        bus.io_loadingValues = 1'b0;
        check({tag, " valid_on_load"}, bus.io_outputValid, 0);
        for (int n = 1; n <= MAX_LAT; n++) begin
            bus.io_value1 = W'($urandom);
            bus.io_value2 = W'($urandom);
            tick();
            if (bus.io_outputValid === 1'b1) begin
                lat = n;
                break;
            end
        end
        check({tag, " completed"}, (lat != 0), 1);
        check({tag, " gcd"}, bus.io_outputGCD, ref_gcd(a, b));
        if (exp_lat >= 0) check({tag, " latency"}, lat, exp_lat);
        else check({tag, " latency_bound"}, (lat <= MAX_LAT), 1);
    endtask

    task automatic check_hold(input int exp_gcd, input string tag);
        tick();
        tick();
        check({tag, " hold_valid"}, bus.io_outputValid, 1);
        check({tag, " hold_gcd"}, bus.io_outputGCD, exp_gcd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset held with a load pending must win.
        bus.io_value1        = 2'd3;
        bus.io_value2        = 2'd2;
        bus.io_loadingValues = 1'b1;
        reset                = 1'b0;
        tick();
        tick();
        check("reset gcd", bus.io_outputGCD, 0);
        check("reset valid", bus.io_outputValid, 0);
        check("reset state", dut.state, IDLE);
        bus.io_loadingValues = 1'b0;
        reset                = 1'b1;
        tick();
        check("idle state", dut.state, IDLE);
        check("idle valid", bus.io_outputValid, 0);

        run_pair(2, 1, 3, "p21");
        check_hold(1, "p21");
        run_pair(3, 3, 2, "p33");
        run_pair(2, 0, 1, "p20");
        run_pair(0, 3, 2, "p03");
        run_pair(0, 0, 1, "p00");

        // Reload while DONE.
        run_pair(2, 1, 3, "p21b");
        run_pair(2, 2, 2, "reload22");
        check_hold(2, "reload22");

        // Holding the load strobe keeps reloading.
        bus.io_loadingValues = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.io_value1 = W'($urandom);
            bus.io_value2 = W'($urandom);
            tick();
            check("hold_load state", dut.state, BUSY);
            check("hold_load valid", bus.io_outputValid, 0);
        end
        run_pair(3, 1, 4, "after_hold31");

        // Reset mid-computation aborts with no stale valid.
        bus.io_value1        = 2'd3;
        bus.io_value2        = 2'd2;
        bus.io_loadingValues = 1'b1;
        tick();
        bus.io_loadingValues = 1'b0;
        reset                = 1'b0;
        tick();
        check("abort gcd", bus.io_outputGCD, 0);
        check("abort valid", bus.io_outputValid, 0);
        check("abort state", dut.state, IDLE);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.io_value1 = W'($urandom);
            bus.io_value2 = W'($urandom);
            tick();
            check("abort no_valid", bus.io_outputValid, 0);
        end

        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                run_pair(a, b, -1, $sformatf("exh_%0d_%0d", a, b));
            end
        end

        for (int i = 0; i < 12; i++) begin
            int ra;
            int rb;
            ra = int'($urandom_range(0, (1 << W) - 1));
            rb = int'($urandom_range(0, (1 << W) - 1));
            run_pair(ra, rb, -1, $sformatf("rnd_%0d_%0d", ra, rb));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
